// File: rtl/line_engine.sv
// Bresenham line rasteriser: latches endpoints and colour from the CPU,
// then streams one framebuffer pixel write per step over valid/ready.
module line_engine #(
  parameter logic [31:0] FB_BASE = 32'h1080_0000,
  parameter int          XRES    = 800,
  parameter int          YRES    = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] line_color,
  input  logic [9:0]  line_point,
  input  logic        line_color_valid,
  input  logic        line_x0_valid,
  input  logic        line_y0_valid,
  input  logic        line_x1_valid,
  input  logic        line_y1_valid,
  input  logic        line_trigger,
  output logic        line_ready,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [31:0] fb_addr,
  output logic [23:0] fb_color
);

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [9:0]  r_x0, r_y0, r_x1, r_y1;
  logic [23:0] r_color;
  logic [9:0]  r_x, r_y;
  logic [10:0] r_dx, r_dy;
  logic        r_xneg, r_yneg;
  logic signed [11:0] r_err;
  logic        r_ready, r_valid;
  logic [31:0] r_addr;
  logic [23:0] r_fcolor;

  logic        w_step, w_done;
  logic [10:0] w_sdx, w_sdy;
  logic signed [12:0] w_e2, w_ndy, w_pdx, w_nerr;
  logic        w_mx, w_my;
  logic [9:0]  w_nx, w_ny;

  function automatic logic f_in(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'(XRES)) && (y < 10'(YRES));
  endfunction

  function automatic logic [31:0] f_addr(input logic [9:0] x,
                                         input logic [9:0] y);
    return FB_BASE | {10'd0, y, x, 2'b00};
  endfunction

  assign w_step = !r_valid || fb_ready;
  assign w_done = (r_x == r_x1) && (r_y == r_y1);

  assign w_sdx = (r_x1 >= r_x0) ? {1'b0, r_x1 - r_x0} : {1'b0, r_x0 - r_x1};
  assign w_sdy = (r_y1 >= r_y0) ? {1'b0, r_y1 - r_y0} : {1'b0, r_y0 - r_y1};

  // One Bresenham step from the current point, err updated in a single add
  assign w_e2  = {r_err, 1'b0};
  assign w_ndy = -$signed({2'b00, r_dy});
  assign w_pdx = $signed({2'b00, r_dx});
  assign w_mx  = w_e2 > w_ndy;
  assign w_my  = w_e2 < w_pdx;
  assign w_nx  = w_mx ? (r_xneg ? r_x - 10'd1 : r_x + 10'd1) : r_x;
  assign w_ny  = w_my ? (r_yneg ? r_y - 10'd1 : r_y + 10'd1) : r_y;
  assign w_nerr = {r_err[11], r_err}
                + (w_mx ? w_ndy : 13'sd0)
                + (w_my ? w_pdx : 13'sd0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (line_trigger) w_state_nx = SETUP;
      SETUP:   w_state_nx = DRAW;
      DRAW:    if (w_step && w_done) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_color  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_xneg   <= 1'b0;
      r_yneg   <= 1'b0;
      r_err    <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_fcolor <= '0;
    end else begin
      r_ready <= (w_state_nx == IDLE);
      unique case (r_state)
        IDLE: begin
          if (line_x0_valid)    r_x0    <= line_point;
          if (line_y0_valid)    r_y0    <= line_point;
          if (line_x1_valid)    r_x1    <= line_point;
          if (line_y1_valid)    r_y1    <= line_point;
          if (line_color_valid) r_color <= line_color[23:0];
        end
        SETUP: begin
          r_x      <= r_x0;
          r_y      <= r_y0;
          r_dx     <= w_sdx;
          r_dy     <= w_sdy;
          r_xneg   <= r_x0 > r_x1;
          r_yneg   <= r_y0 > r_y1;
          r_err    <= {1'b0, w_sdx} - {1'b0, w_sdy};
          r_fcolor <= r_color;
          r_valid  <= f_in(r_x0, r_y0);
          r_addr   <= f_addr(r_x0, r_y0);
        end
        DRAW: begin
          if (w_step) begin
            if (w_done) begin
              r_valid <= 1'b0;
            end else begin
              r_x     <= w_nx;
              r_y     <= w_ny;
              r_err   <= w_nerr[11:0];
              r_valid <= f_in(w_nx, w_ny);
              r_addr  <= f_addr(w_nx, w_ny);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign line_ready = r_ready;
  assign fb_valid   = r_valid;
  assign fb_addr    = r_addr;
  assign fb_color   = r_fcolor;

endmodule

// File: tb/tb_line_engine.sv
// Testbench for line_engine: directed and random lines checked against
// a textbook Bresenham model with clipping and handshake-aware timing.
module tb_line_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] line_color;
  logic [9:0]  line_point;
  logic        line_color_valid, line_x0_valid, line_y0_valid;
  logic        line_x1_valid, line_y1_valid, line_trigger;
  logic        line_ready, fb_valid, fb_ready;
  logic [31:0] fb_addr;
  logic [23:0] fb_color;

  int checks = 0;
  int errors = 0;
  logic [55:0] wq[$];

  always #5 clk = ~clk;

  line_engine dut (
    .clk(clk),
    .rst(rst),
    .line_color(line_color),
    .line_point(line_point),
    .line_color_valid(line_color_valid),
    .line_x0_valid(line_x0_valid),
    .line_y0_valid(line_y0_valid),
    .line_x1_valid(line_x1_valid),
    .line_y1_valid(line_y1_valid),
    .line_trigger(line_trigger),
    .line_ready(line_ready),
    .fb_valid(fb_valid),
    .fb_ready(fb_ready),
    .fb_addr(fb_addr),
    .fb_color(fb_color)
  );

  always @(negedge clk)
    if (!rst && fb_valid && fb_ready) wq.push_back({fb_addr, fb_color});

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes;
    line_x0_valid = 0;
    line_y0_valid = 0;
    line_x1_valid = 0;
    line_y1_valid = 0;
    line_color_valid = 0;
    line_trigger = 0;
  endtask

  task automatic load(input int x0, input int y0, input int x1, input int y1,
                      input logic [23:0] col);
    line_point = x0[9:0]; line_x0_valid = 1; tick; clear_strobes;
    line_point = y0[9:0]; line_y0_valid = 1; tick; clear_strobes;
    line_point = x1[9:0]; line_x1_valid = 1;
    line_color = {8'hA5, col}; line_color_valid = 1; tick; clear_strobes;
    line_point = y1[9:0]; line_y1_valid = 1; line_trigger = 1;
    tick; clear_strobes;
  endtask

  task automatic trigger_only;
    line_trigger = 1; tick; clear_strobes;
  endtask

  // Called in the cycle right after the trigger edge (the SETUP cycle).
  // mode 0: ready=1, 1: random ready, 2: 3-cycle stall on pixel 2,
  // 3: pulse strobes+trigger while busy
  task automatic draw_check(input string name, input int x0, input int y0,
                            input int x1, input int y1,
                            input logic [23:0] col, input int mode);
    logic [55:0] exp[$];
    int x, y, dx, dy, sx, sy, err, e2, npts, c, stalls, nst, n;
    x = x0; y = y0; npts = 0;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    sx = (x0 <= x1) ? 1 : -1;
    sy = (y0 <= y1) ? 1 : -1;
    err = dx - dy;
    forever begin
      npts++;
      if (x < 800 && y < 600)
        exp.push_back({32'h1080_0000 + 32'(y * 4096 + x * 4), col});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx) begin err += dx; y += sy; end
    end
    checks++;
    if (line_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: line_ready=%0b want 0", name, line_ready);
    end
    c = 1; stalls = 0; nst = 0;
    while (!line_ready && c < 8000) begin
      fb_ready = 1;
      if (mode == 1) fb_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2 && wq.size() == 1 && fb_valid && nst < 3) begin
        fb_ready = 0;
        nst++;
        checks++;
        if (fb_addr !== 32'h1080_0004 || fb_color !== col) begin
          errors++;
          $display("FAIL %s stall: addr=%h col=%h want 10800004 %h",
                   name, fb_addr, fb_color, col);
        end
      end
      if (mode == 3 && c == 4) begin
        line_point = 10'h3FF; line_x1_valid = 1; line_trigger = 1;
        line_color = 32'h00AB_CDEF; line_color_valid = 1;
      end else begin
        clear_strobes;
      end
      if (fb_valid && !fb_ready) stalls++;
      tick;
      c++;
    end
    clear_strobes;
    fb_ready = 1;
    checks++;
    if (c !== npts + 2 + stalls) begin
      errors++;
      $display("FAIL %s latency: ready in cycle T+%0d want T+%0d",
               name, c, npts + 2 + stalls);
    end
    if (mode == 2) begin
      checks++;
      if (nst !== 3) begin
        errors++;
        $display("FAIL %s stalls: got %0d want 3", name, nst);
      end
    end
    checks++;
    if (wq.size() !== exp.size()) begin
      errors++;
      $display("FAIL %s count: writes=%0d want %0d", name, wq.size(), exp.size());
    end
    n = (wq.size() < exp.size()) ? wq.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (wq[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s pixel %0d: addr=%h col=%h want addr=%h col=%h",
                 name, i, wq[i][55:24], wq[i][23:0], exp[i][55:24], exp[i][23:0]);
      end
    end
    wq.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (line_ready !== 1'b1 || fb_valid !== 1'b0 ||
        fb_addr !== 32'd0 || fb_color !== 24'd0) begin
      errors++;
      $display("FAIL %s: ready=%0b valid=%0b addr=%h col=%h want 1 0 0 0",
               name, line_ready, fb_valid, fb_addr, fb_color);
    end
  endtask

  task automatic test_reset;
    rst = 1; fb_ready = 1; clear_strobes;
    line_point = '0; line_color = '0;
    tick; tick;
    check_idle_outputs("reset");
    rst = 0;
    tick;
  endtask

  task automatic test_horizontal;
    load(0, 0, 3, 0, 24'hFF0000);
    draw_check("horizontal", 0, 0, 3, 0, 24'hFF0000, 0);
  endtask

  task automatic test_single;
    load(5, 5, 5, 5, 24'h00FF00);
    draw_check("single", 5, 5, 5, 5, 24'h00FF00, 0);
  endtask

  task automatic test_steep;
    load(2, 4, 0, 0, 24'h0000FF);
    draw_check("steep", 2, 4, 0, 0, 24'h0000FF, 0);
  endtask

  task automatic test_backpressure;
    load(0, 0, 3, 0, 24'hFF0000);
    draw_check("backpressure", 0, 0, 3, 0, 24'hFF0000, 2);
  endtask

  task automatic test_clip;
    load(798, 0, 801, 0, 24'h808080);
    draw_check("clip", 798, 0, 801, 0, 24'h808080, 0);
    load(5, 598, 5, 603, 24'h404040);
    draw_check("clip_y", 5, 598, 5, 603, 24'h404040, 1);
  endtask

  task automatic test_busy;
    load(10, 10, 30, 18, 24'h123456);
    draw_check("busy", 10, 10, 30, 18, 24'h123456, 3);
    repeat (3) tick;
    checks++;
    if (line_ready !== 1'b1 || fb_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_retrig: ready=%0b valid=%0b want 1 0",
               line_ready, fb_valid);
    end
    trigger_only;
    draw_check("busy_redraw", 10, 10, 30, 18, 24'h123456, 0);
  endtask

  task automatic test_reset_mid;
    int seen;
    load(0, 100, 700, 120, 24'hC0FFEE);
    repeat (10) tick;
    rst = 1; fb_ready = 0;
    tick;
    rst = 0;
    wq.delete();
    check_idle_outputs("reset_mid");
    fb_ready = 1;
    seen = 0;
    repeat (20) begin
      tick;
      if (fb_valid) seen++;
    end
    checks++;
    if (wq.size() !== 0 || seen !== 0) begin
      errors++;
      $display("FAIL reset_abort: writes=%0d valid_cycles=%0d want 0 0",
               wq.size(), seen);
    end
    wq.delete();
    trigger_only;
    draw_check("reset_cleared", 0, 0, 0, 0, 24'h000000, 0);
  endtask

  task automatic test_random;
    int x0, y0, x1, y1;
    logic [23:0] col;
    for (int i = 0; i < 8; i++) begin
      x0 = $urandom_range(0, 1023);
      y0 = $urandom_range(0, 1023);
      if (i < 4) begin
        x1 = $urandom_range(0, 1023);
        y1 = $urandom_range(0, 1023);
      end else begin
        x1 = x0 + $urandom_range(0, 40) - 20;
        y1 = y0 + $urandom_range(0, 40) - 20;
        if (x1 < 0) x1 = 0;
        if (x1 > 1023) x1 = 1023;
        if (y1 < 0) y1 = 0;
        if (y1 > 1023) y1 = 1023;
      end
      col = 24'($urandom);
      load(x0, y0, x1, y1, col);
      draw_check("random", x0, y0, x1, y1, col, (i % 2 == 0) ? 1 : 0);
    end
  endtask

  initial begin
    test_reset;
    test_horizontal;
    test_single;
    test_steep;
    test_backpressure;
    test_clip;
    test_busy;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_engine.md
# line_engine

Hardware line-drawing responder for the processor's graphics port. It latches endpoint coordinates and colour written by the CPU through the valid-strobed `line_*` interface. On `trigger` it rasterises the segment with integer Bresenham, emitting one framebuffer pixel write per step over a valid/ready handshake toward the memory arbiter. While drawing it deasserts `line_ready`; the CPU must not trigger again until it returns high.

## Interface
- `FB_BASE`, 32'h1080_0000, framebuffer byte base address; bits [21:0] must be zero.
- `XRES`, 800, visible width in pixels; columns ≥ XRES are clipped.
- `YRES`, 600, visible height in pixels; rows ≥ YRES are clipped.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `line_color`  in  32  colour word; bits [23:0] are used.
- `line_point`  in  10  coordinate value for the x0/y0/x1/y1 strobes.
- `line_color_valid`  in  1  capture `line_color[23:0]`.
- `line_x0_valid`, `line_y0_valid`, `line_x1_valid`, `line_y1_valid`  in  1 each  capture `line_point` into that endpoint register.
- `line_trigger`  in  1  start drawing.
- `line_ready`  out  1  high when idle and accepting writes and trigger.
- `fb_valid`  out  1  pixel write request.
- `fb_ready`  in  1  arbiter accepts the request this cycle.
- `fb_addr`  out  32  `FB_BASE | {y[9:0], x[9:0], 2'b00}`.
- `fb_color`  out  24  pixel colour.

## Operation
- States: IDLE, SETUP, DRAW.
- **IDLE**
  - `line_ready` is 1.
  - Each valid strobe loads its register at the clock edge. Several strobes may be asserted in one cycle; all are taken.
  - `line_trigger` moves the engine to SETUP.
  - If `line_trigger` coincides with strobes, SETUP uses the newly written values.
- **SETUP** (1 cycle)
  - dx = |x1−x0| and dy = |y1−y0|, both 11-bit unsigned.
  - sx = +1 if x0 ≤ x1, else −1. sy is derived the same way from y0 and y1.
  - err = dx − dy, 12-bit signed.
  - Current point is (x, y) = (x0, y0). Next state is DRAW.
- **DRAW**, for each current point:
  - In range (x < XRES and y < YRES): drive `fb_valid`=1 with the address and colour. Hold all three stable until `fb_valid && fb_ready`; that handshake is the step event.
  - Out of range: `fb_valid` stays 0 and the step event occurs immediately, one step per cycle.
  - On a step event, if (x, y) == (x1, y1), go to IDLE.
  - Otherwise compute e2 = 2·err (13-bit signed):
    - if e2 > −dy: x += sx.
    - if e2 < dx: y += sy.
    - err += (e2 > −dy ? −dy : 0) + (e2 < dx ? dx : 0), applied as a single update.
- Coordinate arithmetic never wraps, because stepping stops exactly at the endpoint.
- Strobes and `line_trigger` received in SETUP or DRAW are ignored. Registers keep the values captured at trigger.
- Colour is sampled into the pixel path at SETUP. A later colour write does not affect the line in flight.
- Reset:
  - Takes effect in any state, including mid-line.
  - Engine goes to IDLE with `line_ready`=1 and `fb_valid`=0.
  - `fb_addr`=0, `fb_color`=0.
  - Endpoint and colour registers are cleared to 0.
  - No further write of the aborted line is issued.

## Timing
- All outputs are registered.
- Trigger sampled at edge T:
  - `line_ready` falls after edge T.
  - SETUP occupies cycle T+1.
  - First `fb_valid` is visible after edge T+1, in cycle T+2.
- A line of N in-range pixels with `fb_ready` held high takes N cycles of `fb_valid`. `line_ready` rises in cycle T+N+2.
- Each clipped pixel costs exactly 1 cycle. Each backpressure cycle adds 1 cycle.
- Consecutive accepted pixels are back-to-back. `fb_valid` has no bubble between pixels when `fb_ready`=1.
- `fb_valid` never drops without a handshake, except on `rst`.

## Test plan
- **Horizontal line:** write (0,0)→(3,0) with colour 0x00FF0000, then trigger, `fb_ready`=1.
  - Expect exactly 4 writes at 0x10800000, 0x10800004, 0x10800008, 0x1080000C, each with colour FF0000.
  - `line_ready` is high again 6 cycles after trigger.
- **Single point:** (5,5)→(5,5).
  - Expect one write at 0x10805014.
  - `line_ready` returns 3 cycles after trigger.
- **Steep negative octant:** (2,4)→(0,0).
  - Expect writes in the order (2,4), (2,3), (1,2), (1,1), (0,0), then IDLE.
- **Backpressure:** same as the horizontal line, with `fb_ready` low for 3 cycles while the 2nd pixel is presented.
  - `fb_valid`, `fb_addr` (0x10800004) and `fb_color` stay stable throughout.
  - The total time grows by 3 cycles, with no duplicated or dropped pixels.
- **Clipping:** (798,0)→(801,0).
  - Expect writes only for x=798 and x=799.
  - `line_ready` returns 6 cycles after trigger.
- **Busy and reset:**
  - During a draw, pulse `line_x1_valid` with 0x3FF and `line_trigger`. Both are ignored, and the original line completes unchanged.
  - Repeat the line, then assert `rst` mid-line. The next cycle shows `fb_valid`=0, `line_ready`=1 and cleared registers, and no further writes occur.
